// File: rtl/pci_step_pkg.sv
// Shared constants and types for the stepper pulse generator.
// Holds the IO map, the control/status bit positions, the FSM states and the command FIFO entry width.
package pci_step_pkg;

    localparam logic [1:0] ADDR_PERIOD = 2'd0;
    localparam logic [1:0] ADDR_PUSH   = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STEPS  = 2'd3;

    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_ABORT_BIT   = 1;
    localparam int CTRL_CLR_OVF_BIT = 2;

    localparam int STAT_OVF_BIT   = 31;
    localparam int STAT_FULL_BIT  = 30;
    localparam int STAT_EMPTY_BIT = 29;
    localparam int PUSH_DIR_BIT   = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOW,
        ST_HIGH
    } step_state_e;

    // A FIFO entry is packed as {dir, count, period}.
    function automatic int fifo_entry_width(input int periodBits, input int countBits);
        return 1 + countBits + periodBits;
    endfunction

    localparam int FIFO_ENTRY_W = fifo_entry_width(16, 16);

endpackage

// File: rtl/pci_step_gen_if.sv
// IO-space write/read path and the axis outputs of one stepper channel.
interface pci_step_gen_if;

    logic        WR_STB;
    logic [1:0]  WR_ADDR;
    logic [31:0] WR_DATA;
    logic [1:0]  RD_ADDR;
    logic [31:0] RD_DATA;
    logic        STEP_O;
    logic        DIR_O;
    logic        BUSY;
    logic        FIFO_FULL;

    modport master (
        output WR_STB, WR_ADDR, WR_DATA, RD_ADDR,
        input  RD_DATA, STEP_O, DIR_O, BUSY, FIFO_FULL
    );

    modport slave (
        input  WR_STB, WR_ADDR, WR_DATA, RD_ADDR,
        output RD_DATA, STEP_O, DIR_O, BUSY, FIFO_FULL
    );

endinterface

// File: rtl/pci_step_gen_fifo.sv
// Synchronous command FIFO with first-word fall-through head and a flush.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module step_fifo #(
    parameter int WIDTH      = 33,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      pushData_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [WIDTH-1:0]      head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_BITS:0]   level_o
);

    localparam int DEPTH = 2 ** DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] LEVEL_FULL = (DEPTH_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wrPtr_q;
    logic [DEPTH_BITS-1:0] rdPtr_q;
    logic [DEPTH_BITS:0]   level_q;
    logic                  doPush;
    logic                  doPop;

    assign full_o  = (level_q == LEVEL_FULL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rdPtr_q];

    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + DEPTH_BITS'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + DEPTH_BITS'(1);
            end
            level_q <= level_q + (DEPTH_BITS + 1)'(doPush) - (DEPTH_BITS + 1)'(doPop);
        end
    end

endmodule

// File: rtl/pci_step_gen.sv
// One stepper axis behind the PCI target IO BAR: register decode, command FIFO,
// STEP/DIR sequencing FSM and the registered readback mux.
module pci_step_gen #(
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int PULSE_WIDTH     = 8,
    parameter int PERIOD_BITS     = 16,
    parameter int COUNT_BITS      = 16
) (
    input  logic CLK,
    input  logic RST,
    pci_step_gen_if.slave bus
);

    import pci_step_pkg::*;

    localparam int ENTRY_W  = fifo_entry_width(PERIOD_BITS, COUNT_BITS);
    localparam int PW_BITS  = $clog2(PULSE_WIDTH + 1);
    localparam int TIMER_W  = (PERIOD_BITS > PW_BITS) ? PERIOD_BITS : PW_BITS;
    localparam logic [TIMER_W-1:0] PULSE_TICKS = TIMER_W'(PULSE_WIDTH);

    step_state_e              state_q, state_d;
    logic [TIMER_W-1:0]       timer_q, timer_d;
    logic [COUNT_BITS-1:0]    segCount_q, segCount_d;
    logic [PERIOD_BITS-1:0]   segPeriod_q, segPeriod_d;
    logic                     segDir_q, segDir_d;
    logic [31:0]              steps_q, steps_d;
    logic                     step_q, step_d;
    logic [PERIOD_BITS-1:0]   stagedPeriod_q;
    logic                     enable_q;
    logic                     overflow_q;
    logic [31:0]              rdData_q, rdData_d;

    logic                     wrPeriod, wrPush, wrCtrl, abortReq;
    logic                     fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [ENTRY_W-1:0]       fifoHead;
    logic [FIFO_DEPTH_BITS:0] fifoLevel;
    logic [TIMER_W-1:0]       reloadTicks;
    logic                     unusedWrBits;

    assign wrPeriod = bus.WR_STB && (bus.WR_ADDR == ADDR_PERIOD);
    assign wrPush   = bus.WR_STB && (bus.WR_ADDR == ADDR_PUSH);
    assign wrCtrl   = bus.WR_STB && (bus.WR_ADDR == ADDR_CTRL);
    assign abortReq = wrCtrl && bus.WR_DATA[CTRL_ABORT_BIT];
    assign fifoPush = wrPush && !abortReq;
    assign unusedWrBits = ^bus.WR_DATA;

    step_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk_i      (CLK),
        .rst_i      (RST),
        .push_i     (fifoPush),
        .pushData_i ({bus.WR_DATA[PUSH_DIR_BIT], bus.WR_DATA[COUNT_BITS-1:0], stagedPeriod_q}),
        .pop_i      (fifoPop),
        .flush_i    (abortReq),
        .head_o     (fifoHead),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .level_o    (fifoLevel)
    );

    // A zero period still needs one low cycle so DIR has setup time before the edge.
    assign reloadTicks = (segPeriod_q == '0) ? TIMER_W'(1) : TIMER_W'(segPeriod_q);

    // Segment fields are captured on the pop itself because the FIFO head moves on afterwards.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        segCount_d  = segCount_q;
        segPeriod_d = segPeriod_q;
        segDir_d    = segDir_q;
        steps_d     = steps_q;
        fifoPop     = 1'b0;
        if (abortReq) begin
            state_d    = ST_IDLE;
            segCount_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable_q && !fifoEmpty) begin
                        fifoPop     = 1'b1;
                        state_d     = ST_LOAD;
                        segDir_d    = fifoHead[ENTRY_W-1];
                        segCount_d  = fifoHead[PERIOD_BITS +: COUNT_BITS];
                        segPeriod_d = fifoHead[PERIOD_BITS-1:0];
                    end
                end
                ST_LOAD: begin
                    if (segCount_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOW;
                        timer_d = reloadTicks;
                    end
                end
                ST_LOW: begin
                    if (timer_q == TIMER_W'(1)) begin
                        state_d = ST_HIGH;
                        timer_d = PULSE_TICKS;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (timer_q == TIMER_W'(1)) begin
                        segCount_d = segCount_q - COUNT_BITS'(1);
                        steps_d    = steps_q + 32'd1;
                        if (segCount_q == COUNT_BITS'(1)) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_LOW;
                            timer_d = reloadTicks;
                        end
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        step_d = (state_d == ST_HIGH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            segCount_q  <= '0;
            segPeriod_q <= '0;
            segDir_q    <= 1'b0;
            steps_q     <= '0;
            step_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            segCount_q  <= segCount_d;
            segPeriod_q <= segPeriod_d;
            segDir_q    <= segDir_d;
            steps_q     <= steps_d;
            step_q      <= step_d;
        end
    end

    // An abort write leaves ENABLE as it was; only a plain control write changes it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stagedPeriod_q <= '0;
            enable_q       <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            if (wrPeriod) begin
                stagedPeriod_q <= bus.WR_DATA[PERIOD_BITS-1:0];
            end
            if (wrCtrl && !abortReq) begin
                enable_q <= bus.WR_DATA[CTRL_ENABLE_BIT];
            end
            if (fifoPush && fifoFull && !fifoPop) begin
                overflow_q <= 1'b1;
            end else if (wrCtrl && bus.WR_DATA[CTRL_CLR_OVF_BIT]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rdData_d = '0;
        unique case (bus.RD_ADDR)
            ADDR_PERIOD: rdData_d = 32'(stagedPeriod_q);
            ADDR_PUSH: begin
                rdData_d[STAT_OVF_BIT]          = overflow_q;
                rdData_d[STAT_FULL_BIT]         = fifoFull;
                rdData_d[STAT_EMPTY_BIT]        = fifoEmpty;
                rdData_d[FIFO_DEPTH_BITS:0]     = fifoLevel;
            end
            ADDR_CTRL: begin
                rdData_d[31:16]           = 16'(segCount_q);
                rdData_d[CTRL_ENABLE_BIT] = enable_q;
            end
            default: rdData_d = steps_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rdData_q <= '0;
        end else begin
            rdData_q <= rdData_d;
        end
    end

    assign bus.RD_DATA   = rdData_q;
    assign bus.STEP_O    = step_q;
    assign bus.DIR_O     = segDir_q;
    assign bus.BUSY      = (state_q != ST_IDLE) || !fifoEmpty;
    assign bus.FIFO_FULL = fifoFull;

endmodule

// File: doc/pci_step_gen.md
Name: pci_step_gen

Overview:
- Motion back-end that consumes the PCI target's IO-space writes.
- Host writes step segments (period, direction, step count) into a small command FIFO. The block replays them as STEP/DIR pulse trains for one stepper axis.
- Provides a status/readback word path back to the target's read mux.
- One instance per axis, directly downstream of the PCI target's IO BAR.

Parameters:
- FIFO_DEPTH_BITS, 2, log2 of command FIFO depth (4 entries).
- PULSE_WIDTH, 8, STEP_O high time in CLK cycles (>=1).
- PERIOD_BITS, 16, width of the low-time/period field.
- COUNT_BITS, 16, width of the step count field.

Ports:
- CLK  in  1  PCI clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- WR_STB  in  1  one-cycle strobe on a completed IO data-phase write.
- WR_ADDR  in  2  IO word index of the write.
- WR_DATA  in  32  write data (AD_I as captured).
- RD_ADDR  in  2  IO word index for readback.
- RD_DATA  out  32  readback word, registered, 1-cycle latency.
- STEP_O  out  1  step pulse.
- DIR_O  out  1  direction.
- BUSY  out  1  segment in progress or FIFO non-empty.
- FIFO_FULL  out  1  command FIFO full.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, staged period 0, ENABLE 0, OVERFLOW 0, step counter 0. Reset wins over any same-cycle write.
- Register map, writes:
  - addr0 sets staged period = WR_DATA[PERIOD_BITS-1:0].
  - addr1 pushes {WR_DATA[31]=dir, WR_DATA[COUNT_BITS-1:0]=count, staged period} into the FIFO.
  - addr2 is control: bit0 ENABLE (level); bit1 ABORT (self-clearing pulse); bit2 clears OVERFLOW.
  - addr3 write is ignored.
- Register map, reads:
  - addr0: staged period.
  - addr1: {OVERFLOW, FIFO_FULL, FIFO_EMPTY, zeros, level in [FIFO_DEPTH_BITS:0]}.
  - addr2: {remaining count of current segment in [31:16], zeros, ENABLE in bit0}.
  - addr3: total steps emitted, 32-bit, wraps to 0.
- Push while full: entry dropped, OVERFLOW set (sticky). A push and a pop in the same cycle are both performed and the level is unchanged.
- FSM states: IDLE, LOAD, LOW, HIGH.
  - IDLE: if ENABLE & !empty, pop and go to LOAD.
  - LOAD: latch dir/count/period; DIR_O updates this cycle. If count==0, go to IDLE (segment discarded). Otherwise go to LOW with timer = max(period,1).
  - LOW: STEP_O=0, decrement timer. At timer==1, go to HIGH with timer = PULSE_WIDTH.
  - HIGH: STEP_O=1, decrement timer. At timer==1, decrement count and increment the step counter.
    - If count becomes 0, go to IDLE.
    - Otherwise go to LOW with timer = max(period,1).
- Timing:
  - First rising STEP_O occurs max(period,1) cycles after LOAD; this gives DIR setup time.
  - Step-to-step spacing is PULSE_WIDTH + max(period,1) cycles.
  - Back-to-back segments add 2 cycles (IDLE, LOAD).
- ENABLE cleared mid-segment: the current segment completes; no further pops.
- ABORT: next cycle the FSM is in IDLE, STEP_O=0, and the FIFO is flushed. DIR_O, ENABLE and the step counter are held. ABORT takes priority over a same-cycle push (the push is dropped without setting OVERFLOW).
- BUSY = (state!=IDLE) | !empty.
- STEP_O and DIR_O are registered; no glitches.

Decomposition:
- Package pci_step_pkg holds:
  - IO address constants (ADDR_PERIOD=0, ADDR_PUSH=1, ADDR_CTRL=2, ADDR_STEPS=3);
  - control bit positions;
  - the state enum;
  - the FIFO entry width.
- Sub-module step_fifo: synchronous FIFO, parameterised by width and depth bits. Interface is push, pop, flush, full, empty and level, with first-word data always valid.
- The FSM, register decode and read mux live in pci_step_gen.

Test Plan:
- Write addr0=3, addr1=0x8000_0002, addr2=1 -> DIR_O=1, then 2 STEP_O pulses of 8 cycles high, 3 cycles apart. addr3 reads 2 and BUSY falls after the second pulse.
- Push 5 segments with ENABLE=0 -> FIFO_FULL after 4 pushes. 5th push sets OVERFLOW (addr1 bit31=1, level=4). Writing addr2=4 clears OVERFLOW.
- Push count=0 then count=1 with period=0, then enable -> the first segment emits nothing. The second emits 1 pulse, rising 1 cycle after its LOAD.
- Mid-segment (count=100) write addr2=2 -> STEP_O=0 next cycle, FIFO empty, BUSY=0, and addr3 holds the steps emitted so far.
- Assert RST during HIGH -> all outputs 0 next cycle, and addr0..3 read 0.
- Simultaneous pop and push at level 4 -> level stays 4, OVERFLOW stays 0.
